// File: rtl/cpu_multicycle.sv
// rtl/cpu_multicycle.sv - multi-cycle RV32I core with a single shared req/ready memory port
//
// Purpose: executes RV32I as a sequence of FSM states (FETCH, DECODE, EXEC,
// ADDR, MEM, WB, BRANCH, JUMP, HALT) over one instruction/data memory port.
// Halts on ECALL/EBREAK; halts with illegal=1 on unsupported encodings,
// out-of-range registers, misaligned load/store addresses or jump targets.
//
// Parameters:
//   RESET_PC  first fetch address
//   NUM_REGS  32 (RV32I) or 16 (RV32E-style)
//   CNT_W     performance counter width
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   mem_req/mem_we     request valid / write (SW) when 1
//   mem_addr           word-aligned byte address
//   mem_wdata          store data
//   mem_rdata          read data, taken in the mem_req & mem_ready cycle
//   mem_ready          completes the transfer in the mem_req & mem_ready cycle
//   halted, illegal    sticky halt status and illegal cause
//   cycle_cnt          cycles since reset until halt      (CPU_PERF_CNT_EN)
//   instret_cnt        retired instructions               (CPU_PERF_CNT_EN)
//
// Optional feature macro: CPU_PERF_CNT_EN (performance counters).

module cpu_multicycle #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NUM_REGS = 32,
  parameter int          CNT_W    = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              halted,
  output logic              illegal
`ifdef CPU_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  instret_cnt
`endif
);

  localparam int RW = $clog2(NUM_REGS);

  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_IMM    = 7'h13;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC, S_ADDR, S_MEM, S_WB, S_BRANCH, S_JUMP, S_HALT
  } state_t;

  state_t      state;
  logic [31:0] pc, old_pc, ir;
  logic [31:0] a_q, b_q, alu_out, mdr, ea;
  logic [31:0] regs [NUM_REGS];

  // Instruction fields and immediates, decoded from the held instruction.
  logic [6:0]  opcode, f7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign f3     = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign f7     = ir[31:25];
  assign imm_i  = {{20{ir[31]}}, ir[31:20]};
  assign imm_s  = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b  = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_u  = {ir[31:12], 12'b0};
  assign imm_j  = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

  logic is_store;
  assign is_store = (opcode == OPC_STORE);

  // Legality: encoding checks plus register-index range (matters for NUM_REGS=16).
  logic bad_op, bad_reg, use_rd, use_rs1, use_rs2;

  always_comb begin
    bad_op  = 1'b0;
    use_rd  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (opcode)
      OPC_OP: begin
        use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
        if (!(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))))
          bad_op = 1'b1;
      end
      OPC_IMM: begin
        use_rd = 1'b1; use_rs1 = 1'b1;
        if (f3 == 3'd1 && f7 != 7'h00)
          bad_op = 1'b1;
        if (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20)
          bad_op = 1'b1;
      end
      OPC_LUI, OPC_AUIPC, OPC_JAL: use_rd = 1'b1;
      OPC_JALR: begin
        use_rd = 1'b1; use_rs1 = 1'b1;
        if (f3 != 3'd0) bad_op = 1'b1;
      end
      OPC_BRANCH: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1;
        if (f3 == 3'd2 || f3 == 3'd3) bad_op = 1'b1;
      end
      OPC_LOAD: begin
        use_rd = 1'b1; use_rs1 = 1'b1;
        if (f3 != 3'd2) bad_op = 1'b1;
      end
      OPC_STORE: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1;
        if (f3 != 3'd2) bad_op = 1'b1;
      end
      OPC_SYSTEM: begin
        if (ir != 32'h0000_0073 && ir != 32'h0010_0073) bad_op = 1'b1;
      end
      default: bad_op = 1'b1;
    endcase
    bad_reg = (use_rd  && ({27'd0, rd}  >= NUM_REGS)) ||
              (use_rs1 && ({27'd0, rs1} >= NUM_REGS)) ||
              (use_rs2 && ({27'd0, rs2} >= NUM_REGS));
  end

  // Register file read; x0 and out-of-range indices read as zero.
  logic [31:0] rs1_val, rs2_val;
  assign rs1_val = (rs1 == 5'd0 || {27'd0, rs1} >= NUM_REGS) ? 32'd0 : regs[rs1[RW-1:0]];
  assign rs2_val = (rs2 == 5'd0 || {27'd0, rs2} >= NUM_REGS) ? 32'd0 : regs[rs2[RW-1:0]];

  // ALU: OP uses B, OP-IMM uses imm_i; func7[5] selects SUB (OP only) and SRA.
  logic [31:0] alu_b, alu_res;
  logic [4:0]  shamt;
  assign alu_b = (opcode == OPC_OP) ? b_q : imm_i;
  assign shamt = alu_b[4:0];

  always_comb begin
    alu_res = 32'd0;
    case (f3)
      3'd0: alu_res = (opcode == OPC_OP && f7[5]) ? a_q - alu_b : a_q + alu_b;
      3'd1: alu_res = a_q << shamt;
      3'd2: alu_res = {31'd0, $signed(a_q) < $signed(alu_b)};
      3'd3: alu_res = {31'd0, a_q < alu_b};
      3'd4: alu_res = a_q ^ alu_b;
      3'd5: alu_res = f7[5] ? 32'($signed(a_q) >>> shamt) : a_q >> shamt;
      3'd6: alu_res = a_q | alu_b;
      3'd7: alu_res = a_q & alu_b;
      default: alu_res = 32'd0;
    endcase
  end

  logic br_taken;
  always_comb begin
    br_taken = 1'b0;
    case (f3)
      3'd0: br_taken = (a_q == b_q);
      3'd1: br_taken = (a_q != b_q);
      3'd4: br_taken = ($signed(a_q) <  $signed(b_q));
      3'd5: br_taken = ($signed(a_q) >= $signed(b_q));
      3'd6: br_taken = (a_q <  b_q);
      3'd7: br_taken = (a_q >= b_q);
      default: br_taken = 1'b0;
    endcase
  end

  logic [31:0] ea_calc, jmp_tgt;
  assign ea_calc = a_q + (is_store ? imm_s : imm_i);
  assign jmp_tgt = (opcode == OPC_JAL) ? old_pc + imm_j : (a_q + imm_i) & ~32'd1;

  // Port outputs decode from held state, so they stay stable until mem_ready.
  assign mem_req   = rst_n && (state == S_FETCH || state == S_MEM);
  assign mem_we    = (state == S_MEM) && is_store;
  assign mem_addr  = (state == S_MEM) ? ea : pc;
  assign mem_wdata = b_q;

`ifdef CPU_PERF_CNT_EN
  logic retire;
  assign retire = (state == S_WB) || (state == S_BRANCH) ||
                  (state == S_JUMP && !jmp_tgt[1]) ||
                  (state == S_MEM && is_store && mem_ready);
`else
  logic unused_cnt_w;
  assign unused_cnt_w = (CNT_W > 0);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_FETCH;
      pc      <= RESET_PC;
      old_pc  <= 32'd0;
      ir      <= 32'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      alu_out <= 32'd0;
      mdr     <= 32'd0;
      ea      <= 32'd0;
      halted  <= 1'b0;
      illegal <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 32'd0;
`ifdef CPU_PERF_CNT_EN
      cycle_cnt   <= '0;
      instret_cnt <= '0;
`endif
    end else begin
`ifdef CPU_PERF_CNT_EN
      if (state != S_HALT) cycle_cnt <= cycle_cnt + 1'b1;
      if (retire) instret_cnt <= instret_cnt + 1'b1;
`endif
      case (state)
        S_FETCH: begin
          if (mem_ready) begin
            ir     <= mem_rdata;
            old_pc <= pc;
            state  <= S_DECODE;
          end
        end
        S_DECODE: begin
          a_q <= rs1_val;
          b_q <= rs2_val;
          if (bad_op || bad_reg) begin
            state   <= S_HALT;
            halted  <= 1'b1;
            illegal <= 1'b1;
          end else begin
            case (opcode)
              OPC_LOAD, OPC_STORE: state <= S_ADDR;
              OPC_BRANCH:          state <= S_BRANCH;
              OPC_JAL, OPC_JALR:   state <= S_JUMP;
              OPC_SYSTEM: begin
                // pc still holds the ECALL/EBREAK address
                state  <= S_HALT;
                halted <= 1'b1;
              end
              default:             state <= S_EXEC;
            endcase
          end
        end
        S_EXEC: begin
          if (opcode == OPC_LUI)        alu_out <= imm_u;
          else if (opcode == OPC_AUIPC) alu_out <= old_pc + imm_u;
          else                          alu_out <= alu_res;
          state <= S_WB;
        end
        S_ADDR: begin
          ea <= ea_calc;
          if (ea_calc[1:0] != 2'b00) begin
            state   <= S_HALT;
            halted  <= 1'b1;
            illegal <= 1'b1;
          end else begin
            state <= S_MEM;
          end
        end
        S_MEM: begin
          if (mem_ready) begin
            if (is_store) begin
              pc    <= old_pc + 32'd4;
              state <= S_FETCH;
            end else begin
              mdr   <= mem_rdata;
              state <= S_WB;
            end
          end
        end
        S_WB: begin
          if (rd != 5'd0)
            regs[rd[RW-1:0]] <= (opcode == OPC_LOAD) ? mdr : alu_out;
          pc    <= old_pc + 32'd4;
          state <= S_FETCH;
        end
        S_BRANCH: begin
          pc    <= br_taken ? old_pc + imm_b : old_pc + 32'd4;
          state <= S_FETCH;
        end
        S_JUMP: begin
          if (jmp_tgt[1]) begin
            state   <= S_HALT;
            halted  <= 1'b1;
            illegal <= 1'b1;
          end else begin
            if (rd != 5'd0) regs[rd[RW-1:0]] <= old_pc + 32'd4;
            pc    <= jmp_tgt;
            state <= S_FETCH;
          end
        end
        S_HALT: state <= S_HALT;
        default: begin
          state   <= S_HALT;
          halted  <= 1'b1;
          illegal <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_multicycle.sv
// tb/tb_cpu_multicycle.sv - directed self-checking bench for cpu_multicycle

module tb_cpu_multicycle;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req, mem_we, mem_ready, halted, illegal;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        b_mem_req, b_mem_we, b_mem_ready, b_halted, b_illegal;
  logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
`ifdef CPU_PERF_CNT_EN
  logic [63:0] cycle_cnt, instret_cnt, b_cycle_cnt, b_instret_cnt;
`endif

  always #5 clk = ~clk;

  cpu_multicycle #(.RESET_PC(32'h100)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .halted(halted), .illegal(illegal)
`ifdef CPU_PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
  );

  cpu_multicycle #(.RESET_PC(32'h0), .NUM_REGS(16)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .mem_ready(b_mem_ready),
    .halted(b_halted), .illegal(b_illegal)
`ifdef CPU_PERF_CNT_EN
    , .cycle_cnt(b_cycle_cnt), .instret_cnt(b_instret_cnt)
`endif
  );

  // dut_b: zero-wait memory holding ADD x20,x1,x2 at address 0
  assign b_mem_ready = b_mem_req;
  assign b_mem_rdata = (b_mem_addr == 32'h0) ? 32'h00208A33 : 32'h0;

  // dut_a memory: data 0x000-0x0FF with data_wait wait states, code 0x100-0x1FF zero-wait
  logic [31:0] imem [0:63];
  logic [31:0] dmem [0:63];
  int          data_wait;
  int          wait_cnt;
  int          cyc;
  logic [31:0] last_waddr, last_wdata;
  logic [31:0] f_addr [$];
  int          f_cyc  [$];

  assign mem_rdata = (mem_addr < 32'h100) ? dmem[mem_addr[7:2]] : imem[mem_addr[7:2]];
  assign mem_ready = mem_req && ((mem_addr >= 32'h100) || (wait_cnt >= data_wait));

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) wait_cnt <= 0;
    else if (mem_req) begin
      if (mem_ready) begin
        wait_cnt <= 0;
        if (mem_we) begin
          dmem[mem_addr[7:2]] <= mem_wdata;
          last_waddr <= mem_addr;
          last_wdata <= mem_wdata;
        end else if (mem_addr >= 32'h100) begin
          f_addr.push_back(mem_addr);
          f_cyc.push_back(cyc);
        end
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 64; i++) imem[i] = 32'h0;
  endtask

  task automatic put(input logic [31:0] addr, input logic [31:0] w);
    imem[addr[7:2]] = w;
  endtask

  // Cycles between the fetch of address a (first at/after index base) and the next fetch.
  function automatic int lat(input int base, input logic [31:0] a);
    for (int i = base; i + 1 < f_addr.size(); i++)
      if (f_addr[i] == a) return f_cyc[i+1] - f_cyc[i];
    return -1;
  endfunction

  function automatic logic [31:0] nxt(input int base, input logic [31:0] a);
    for (int i = base; i + 1 < f_addr.size(); i++)
      if (f_addr[i] == a) return f_addr[i+1];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic wait_halt(input int budget);
    int n;
    n = 0;
    while (!halted && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("halt_reached", {63'd0, halted}, 64'd1);
  endtask

  int base;

  initial begin
    cyc = 0;
    wait_cnt = 0;
    data_wait = 2;
    last_waddr = 32'h0;
    last_wdata = 32'h0;
    rst_n = 1'b0;

    // Run 1: ALU, SW/LW with 2 data wait states, branches, jumps, ECALL
    clear_imem();
    put(32'h100, 32'h00500093); // ADDI x1,x0,5
    put(32'h104, 32'hFFD00113); // ADDI x2,x0,-3
    put(32'h108, 32'h002081B3); // ADD  x3,x1,x2
    put(32'h10C, 32'h40110233); // SUB  x4,x2,x1
    put(32'h110, 32'h00302423); // SW   x3,8(x0)
    put(32'h114, 32'h00802283); // LW   x5,8(x0)
    put(32'h118, 32'h00009463); // BNE  x1,x0,+8
    put(32'h11C, 32'h00100393); // ADDI x7,x0,1 (skipped)
    put(32'h120, 32'h00008463); // BEQ  x1,x0,+8
    put(32'h124, 32'h0080006F); // JAL  x0,+8
    put(32'h128, 32'h00000073); // ECALL
    put(32'h12C, 32'hFFDFF0EF); // JAL  x1,-4
    repeat (3) @(negedge clk);
    #1;
    check("reset_req", {63'd0, mem_req}, 64'd0);
    check("reset_halted", {63'd0, halted}, 64'd0);
    check("reset_illegal", {63'd0, illegal}, 64'd0);
    check("reset_pc", {32'd0, dut_a.pc}, 64'h100);
    base = f_addr.size();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("first_req", {63'd0, mem_req}, 64'd1);
    check("first_addr", {32'd0, mem_addr}, 64'h100);
    check("first_we", {63'd0, mem_we}, 64'd0);
    wait_halt(500);
    check("x3", {32'd0, dut_a.regs[3]}, 64'h2);
    check("x4", {32'd0, dut_a.regs[4]}, 64'hFFFF_FFF8);
    check("x5", {32'd0, dut_a.regs[5]}, 64'h2);
    check("x7_skipped", {32'd0, dut_a.regs[7]}, 64'h0);
    check("x1_link", {32'd0, dut_a.regs[1]}, 64'h130);
    check("sw_addr", {32'd0, last_waddr}, 64'h8);
    check("sw_data", {32'd0, last_wdata}, 64'h2);
    check("lat_addi", 64'(lat(base, 32'h100)), 64'd4);
    check("lat_add", 64'(lat(base, 32'h108)), 64'd4);
    check("lat_sub", 64'(lat(base, 32'h10C)), 64'd4);
    check("lat_sw_2ws", 64'(lat(base, 32'h110)), 64'd6);
    check("lat_lw_2ws", 64'(lat(base, 32'h114)), 64'd7);
    check("lat_bne", 64'(lat(base, 32'h118)), 64'd3);
    check("bne_taken", {32'd0, nxt(base, 32'h118)}, 64'h120);
    check("beq_not_taken", {32'd0, nxt(base, 32'h120)}, 64'h124);
    check("lat_jal", 64'(lat(base, 32'h12C)), 64'd3);
    check("jal_back", {32'd0, nxt(base, 32'h12C)}, 64'h128);
    check("ecall_illegal", {63'd0, illegal}, 64'd0);
    check("ecall_pc", {32'd0, dut_a.pc}, 64'h128);
    @(negedge clk);
    check("halt_req", {63'd0, mem_req}, 64'd0);

    // Run 2: shifts/compares/LUI/AUIPC, then misaligned LW
    rst_n = 1'b0;
    clear_imem();
    put(32'h100, 32'hFF800093); // ADDI  x1,x0,-8
    put(32'h104, 32'h4010D413); // SRAI  x8,x1,1
    put(32'h108, 32'h001034B3); // SLTU  x9,x0,x1
    put(32'h10C, 32'h0000A533); // SLT   x10,x1,x0
    put(32'h110, 32'h123455B7); // LUI   x11,0x12345
    put(32'h114, 32'h00001617); // AUIPC x12,1
    put(32'h118, 32'h00202303); // LW    x6,2(x0)
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_halt(500);
    check("x8_srai", {32'd0, dut_a.regs[8]}, 64'hFFFF_FFFC);
    check("x9_sltu", {32'd0, dut_a.regs[9]}, 64'h1);
    check("x10_slt", {32'd0, dut_a.regs[10]}, 64'h1);
    check("x11_lui", {32'd0, dut_a.regs[11]}, 64'h1234_5000);
    check("x12_auipc", {32'd0, dut_a.regs[12]}, 64'h1114);
    check("misalign_illegal", {63'd0, illegal}, 64'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("misalign_req", {63'd0, mem_req}, 64'd0);
    end
    check("rv32e_halted", {63'd0, b_halted}, 64'd1);
    check("rv32e_illegal", {63'd0, b_illegal}, 64'd1);

    // Run 3: reset in the middle of a waiting LW
    rst_n = 1'b0;
    clear_imem();
    put(32'h100, 32'h00802283); // LW x5,8(x0)
    data_wait = 50;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 20 && !(mem_req && mem_addr == 32'h8); n++) @(negedge clk);
    check("mid_mem_reached", {32'd0, mem_addr}, 64'h8);
    rst_n = 1'b0;
    #1;
    check("mid_mem_reset_req", {63'd0, mem_req}, 64'd0);
    @(negedge clk);
`ifdef CPU_PERF_CNT_EN
    check("rst_cycle_cnt", cycle_cnt, 64'd0);
    check("rst_instret_cnt", instret_cnt, 64'd0);
`endif

    // Run 4: three ADDIs then ECALL, zero wait
    clear_imem();
    put(32'h100, 32'h00500093); // ADDI x1,x0,5
    put(32'h104, 32'hFFD00113); // ADDI x2,x0,-3
    put(32'h108, 32'h00100193); // ADDI x3,x0,1
    put(32'h10C, 32'h00000073); // ECALL
    data_wait = 0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_halt(200);
    repeat (3) @(negedge clk);
    check("run4_x3", {32'd0, dut_a.regs[3]}, 64'h1);
    check("run4_x2", {32'd0, dut_a.regs[2]}, 64'hFFFF_FFFD);
    check("run4_illegal", {63'd0, illegal}, 64'd0);
`ifdef CPU_PERF_CNT_EN
    check("perf_instret", instret_cnt, 64'd3);
    check("perf_cycle", cycle_cnt, 64'd14);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
